// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller. Reads the current PC from an external PC
// register, fetches the word at that address over a req/ack handshake,
// presents it to the IF/ID stage and then tells the PC register what to load
// next: either the sequential PC + PC_INC or a branch/jump redirect target.
//
// Ports:
//   clock          system clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   pc_in          current PC from the PC register
//   nextpc         value the PC register loads when pc_enable is high
//   pc_enable      one-cycle load strobe for the PC register
//   imem_req       fetch request to instruction memory
//   imem_addr      fetch address (pc_in)
//   imem_ack       memory returns imem_data in this cycle
//   imem_data      instruction word from memory
//   stall          hazard unit: IF/ID cannot take a new instruction
//   branch_taken   one-cycle redirect request to branch_target
//   branch_target  branch destination
//   jump           one-cycle redirect request to jump_target (wins over branch)
//   jump_target    jump destination
//   instr_out      fetched instruction (NOP after reset)
//   pc_plus4       link value: address of instr_out + PC_INC
//   instr_valid    instr_out / pc_plus4 hold a live instruction
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] nextpc,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        VALID    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic        pending_q, pending_d;   // redirect seen while a fetch was outstanding
    logic [31:0] target_q,  target_d;    // latched redirect destination
    logic [31:0] instr_q,   instr_d;
    logic [31:0] link_q,    link_d;
    logic [31:0] nextpc_q,  nextpc_d;    // last value driven on nextpc

    logic        redirect_now;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_tgt;
    logic [31:0] seq_pc;
    logic        pc_en;
    logic [31:0] pc_val;

    // Jump wins over branch; targets are forced onto a word boundary.
    assign redirect_now = jump | branch_taken;
    assign redirect_raw = jump ? jump_target : branch_target;
    assign redirect_tgt = redirect_raw & 32'hFFFF_FFFC;
    assign seq_pc       = pc_in + PC_INC;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        target_d  = target_q;
        instr_d   = instr_q;
        link_d    = link_q;
        pc_en     = 1'b0;
        pc_val    = nextpc_q;

        case (state_q)
            IDLE: begin
                if (redirect_now) begin
                    target_d = redirect_tgt;
                    state_d  = REDIRECT;
                end else begin
                    state_d  = FETCH;
                end
            end

            FETCH: begin
                if (imem_ack) begin
                    if (pending_q || redirect_now) begin
                        // Returned word belongs to the abandoned path: drop it.
                        if (redirect_now) begin
                            target_d = redirect_tgt;
                        end
                        state_d = REDIRECT;
                    end else begin
                        instr_d = imem_data;
                        link_d  = seq_pc;
                        state_d = VALID;
                    end
                end else if (redirect_now) begin
                    // The request in flight cannot be cancelled; remember the
                    // redirect and squash the data when it arrives.
                    target_d  = redirect_tgt;
                    pending_d = 1'b1;
                end
            end

            VALID: begin
                if (redirect_now) begin
                    // A redirect overrides stall: the instruction is flushed.
                    pc_en   = 1'b1;
                    pc_val  = redirect_tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_en   = 1'b1;
                    pc_val  = seq_pc;
                    state_d = FETCH;
                end
            end

            REDIRECT: begin
                pc_en     = 1'b1;
                pc_val    = redirect_now ? redirect_tgt : target_q;
                pending_d = 1'b0;
                state_d   = FETCH;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        nextpc_d = pc_val;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            target_q  <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            link_q    <= 32'h0000_0000;
            nextpc_q  <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            instr_q   <= instr_d;
            link_q    <= link_d;
            nextpc_q  <= nextpc_d;
        end
    end

    // pc_enable only fires in VALID or REDIRECT, and both always move to
    // FETCH, so it can never be high on two consecutive cycles.
    assign pc_enable   = pc_en;
    assign nextpc      = pc_val;
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_in;
    assign instr_valid = (state_q == VALID);
    assign instr_out   = instr_q;
    assign pc_plus4    = link_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. A small PC register model closes the loop
// (loads nextpc on pc_enable). Expected instruction/link pairs are queued when
// an acknowledged fetch is driven and popped when instr_valid appears.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] nextpc;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] link;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_in         (pc_in),
        .nextpc        (nextpc),
        .pc_enable     (pc_enable),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .instr_out     (instr_out),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // PC register model.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_in <= 32'h0000_0000;
        end else if (pc_enable) begin
            pc_in <= nextpc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            misses++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] link);
        exp_t e;
        e.instr = instr;
        e.link  = link;
        sb.push_back(e);
    endtask

    // Waits (bounded) for instr_valid, then compares against the scoreboard.
    task automatic expect_instr(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (instr_valid !== 1'b1 && n < 4) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            vectors++;
            misses++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instr_out, e.instr);
            chk({tag, "_link"},  pc_plus4,  e.link);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_data     = 32'h0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;

        // ---- reset values ----
        #1;
        chk("rst_req",    {31'b0, imem_req},    32'd0);
        chk("rst_pcen",   {31'b0, pc_enable},   32'd0);
        chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
        chk("rst_instr",  instr_out,            32'h0);
        chk("rst_link",   pc_plus4,             32'h0);
        chk("rst_nextpc", nextpc,               32'h0);

        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);

        // ---- test 1: basic fetch with same-cycle ack ----
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'h2008_0005;
        push_exp(32'h2008_0005, 32'h4);
        #1;
        chk("t1_req",  {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr,         32'h0);
        tick();
        imem_ack = 1'b0;
        stall    = 1'b0;
        #1;
        expect_instr("t1");
        chk("t1_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("t1_nextpc", nextpc,             32'h4);
        tick();
        #1;
        chk("t1_req2",   {31'b0, imem_req},    32'd1);
        chk("t1_addr2",  imem_addr,            32'h4);
        chk("t1_vclr",   {31'b0, instr_valid}, 32'd0);
        chk("t1_hold",   nextpc,               32'h4);

        // ---- test 2: stall for 3 cycles while VALID ----
        imem_ack  = 1'b1;
        imem_data = 32'h8C09_0004;
        push_exp(32'h8C09_0004, 32'h8);
        tick();
        imem_ack = 1'b0;
        stall    = 1'b1;
        #1;
        expect_instr("t2");
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_pcen",  {31'b0, pc_enable},   32'd0);
            chk("t2_stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("t2_stall_instr", instr_out,            32'h8C09_0004);
            if (i < 2) begin
                tick();
                #1;
            end
        end
        tick();
        stall = 1'b0;
        #1;
        chk("t2_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("t2_nextpc", nextpc,             32'h8);

        // ---- test 3: branch during FETCH, ack two cycles later ----
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        #1;
        chk("t3_req",  {31'b0, imem_req},  32'd1);
        chk("t3_addr", imem_addr,          32'h8);
        chk("t3_pcen", {31'b0, pc_enable}, 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("t3_req_held", {31'b0, imem_req}, 32'd1);
        chk("t3_addr_held", imem_addr,        32'h8);
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        #1;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t3_valid", {31'b0, instr_valid}, 32'd0);
        chk("t3_pcen",  {31'b0, pc_enable},   32'd1);
        chk("t3_nextpc", nextpc,              32'h40);
        tick();
        #1;
        chk("t3_addr_new", imem_addr,            32'h40);
        chk("t3_valid2",   {31'b0, instr_valid}, 32'd0);

        // ---- test 4: jump and branch together while stalled in VALID ----
        imem_ack  = 1'b1;
        imem_data = 32'h0000_0020;
        push_exp(32'h0000_0020, 32'h44);
        tick();
        imem_ack      = 1'b0;
        stall         = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        #1;
        expect_instr("t4");
        chk("t4_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("t4_nextpc", nextpc,             32'h100);
        tick();
        jump         = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        #1;
        chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_addr",  imem_addr,            32'h100);

        // ---- test 5: wrap-around and target alignment ----
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        imem_ack    = 1'b1;
        imem_data   = 32'hDEAD_0001;
        tick();
        jump     = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("t5_valid",  {31'b0, instr_valid}, 32'd0);
        chk("t5_pcen",   {31'b0, pc_enable},   32'd1);
        chk("t5_nextpc", nextpc,               32'hFFFF_FFFC);
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'h0123_4567;
        push_exp(32'h0123_4567, 32'h0);
        #1;
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        #1;
        expect_instr("t5");
        chk("t5_wrap_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("t5_wrap_nextpc", nextpc,             32'h0);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        #1;
        chk("t5_addr0", imem_addr, 32'h0);
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        imem_data    = 32'h1111_1111;
        #1;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("t5_align_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("t5_align_nextpc", nextpc,             32'h40);

        // ---- new redirect in the REDIRECT cycle overrides the latched one ----
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        imem_ack      = 1'b1;
        imem_data     = 32'h2222_2222;
        #1;
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h300;
        #1;
        chk("rd_pcen",   {31'b0, pc_enable}, 32'd1);
        chk("rd_nextpc", nextpc,             32'h300);
        tick();
        jump = 1'b0;
        #1;
        chk("rd_pcen_off", {31'b0, pc_enable}, 32'd0);
        chk("rd_addr",     imem_addr,          32'h300);

        // ---- test 6: asynchronous reset while a request is outstanding ----
        chk("t6_req_pre", {31'b0, imem_req}, 32'd1);
        #1;
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hCAFE_F00D;
        #1;
        chk("t6_req",    {31'b0, imem_req},    32'd0);
        chk("t6_valid",  {31'b0, instr_valid}, 32'd0);
        chk("t6_pcen",   {31'b0, pc_enable},   32'd0);
        chk("t6_nextpc", nextpc,               32'h0);
        chk("t6_link",   pc_plus4,             32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t6_idle_req",   {31'b0, imem_req},    32'd0);
        chk("t6_idle_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'h2009_0007;
        push_exp(32'h2009_0007, 32'h4);
        #1;
        chk("t6_fetch_req",   {31'b0, imem_req},    32'd1);
        chk("t6_fetch_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_fetch_addr",  imem_addr,            32'h0);
        tick();
        imem_ack = 1'b0;
        #1;
        expect_instr("t6");
        chk("t6_nextpc2", nextpc, 32'h4);

        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
